// File: rtl/dat_scheduler.sv
// Two-port round-robin arbiter and sequencer in front of control_DAT.
// It latches the winner's transfer config, tracks the transfer, and uses a watchdog to reset a hung DAT controller.
module dat_scheduler #(
  parameter int unsigned       WDOG_W     = 20,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 20'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        mb0,
  input  logic        mb1,
  input  logic [3:0]  bs0,
  input  logic [3:0]  bs1,
  input  logic        toen0,
  input  logic        toen1,
  input  logic [15:0] to0,
  input  logic [15:0] to1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic        dat_newService,
  output logic        dat_writeRead,
  output logic        dat_multiblock,
  output logic        dat_timeoutenable,
  output logic [3:0]  dat_blockSize,
  output logic [15:0] dat_timeout,
  output logic        dat_reset,
  input  logic        dat_complete,
  input  logic        dat_idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_ABORT,
    S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic                busy_q, busy_d;
  logic                newservice_q, newservice_d;
  logic                dat_reset_q, dat_reset_d;
  logic                wr_q, wr_d;
  logic                mb_q, mb_d;
  logic                toen_q, toen_d;
  logic [3:0]          bs_q, bs_d;
  logic [15:0]         to_q, to_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                last_q, last_d;
  logic                abort_second_q, abort_second_d;

  logic                pick;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                wdog_expire;
  logic                start_abort;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    done_d         = '0;
    err_d          = '0;
    newservice_d   = newservice_q;
    dat_reset_d    = dat_reset_q;
    wr_d           = wr_q;
    mb_d           = mb_q;
    toen_d         = toen_q;
    bs_d           = bs_q;
    to_d           = to_q;
    wdog_d         = wdog_q;
    last_d         = last_q;
    abort_second_d = abort_second_q;
    start_abort    = 1'b0;

    // Tie goes to the port that was not served last.
    pick        = (req0 && req1) ? ~last_q : req1;
    // Abort fires on the edge where the saturating count reaches the limit.
    wdog_inc    = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
    wdog_expire = (WDOG_LIMIT != '0) && (wdog_inc == WDOG_LIMIT);

    case (state_q)
      S_IDLE: begin
        if (dat_idle && (req0 || req1)) begin
          gnt_d        = pick ? 2'b10 : 2'b01;
          wr_d         = pick ? wr1 : wr0;
          mb_d         = pick ? mb1 : mb0;
          toen_d       = pick ? toen1 : toen0;
          bs_d         = pick ? bs1 : bs0;
          to_d         = pick ? to1 : to0;
          newservice_d = 1'b1;
          wdog_d       = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d = wdog_inc;
        if (wdog_expire) begin
          start_abort = 1'b1;
        end else if (!dat_idle) begin
          newservice_d = 1'b0;
          state_d      = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        wdog_d = wdog_inc;
        if (dat_complete) begin
          done_d  = gnt_q;
          state_d = S_RELEASE;
        end else if (wdog_expire) begin
          start_abort = 1'b1;
        end
      end
      S_ABORT: begin
        if (!abort_second_q) begin
          abort_second_d = 1'b1;
        end else begin
          abort_second_d = 1'b0;
          dat_reset_d    = 1'b0;
          state_d        = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (dat_idle) begin
          gnt_d   = '0;
          last_d  = gnt_q[1];
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_abort) begin
      newservice_d   = 1'b0;
      dat_reset_d    = 1'b1;
      err_d          = gnt_q;
      abort_second_d = 1'b0;
      state_d        = S_ABORT;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      gnt_q          <= '0;
      done_q         <= '0;
      err_q          <= '0;
      busy_q         <= 1'b0;
      newservice_q   <= 1'b0;
      dat_reset_q    <= 1'b0;
      wr_q           <= 1'b0;
      mb_q           <= 1'b0;
      toen_q         <= 1'b0;
      bs_q           <= '0;
      to_q           <= '0;
      wdog_q         <= '0;
      last_q         <= 1'b1;
      abort_second_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      newservice_q   <= newservice_d;
      dat_reset_q    <= dat_reset_d;
      wr_q           <= wr_d;
      mb_q           <= mb_d;
      toen_q         <= toen_d;
      bs_q           <= bs_d;
      to_q           <= to_d;
      wdog_q         <= wdog_d;
      last_q         <= last_d;
      abort_second_q <= abort_second_d;
    end
  end

  assign gnt0              = gnt_q[0];
  assign gnt1              = gnt_q[1];
  assign done0             = done_q[0];
  assign done1             = done_q[1];
  assign err0              = err_q[0];
  assign err1              = err_q[1];
  assign busy              = busy_q;
  assign dat_newService    = newservice_q;
  assign dat_writeRead     = wr_q;
  assign dat_multiblock    = mb_q;
  assign dat_timeoutenable = toen_q;
  assign dat_blockSize     = bs_q;
  assign dat_timeout       = to_q;
  assign dat_reset         = dat_reset_q;

endmodule

// File: doc/dat_scheduler.md
# dat_scheduler

Arbiter and sequencer in front of `control_DAT`: shares the single DAT control/physical path between two requesters, port 0 (DMA) and port 1 (PIO/CPU). It latches the winning requester's transfer configuration and drives the `control_DAT` request inputs. It then tracks the transfer through `complete` and `IDLE_out`, reports done/error per port, and aborts hung transfers with a watchdog that pulses the DAT controller's synchronous reset.

## Interface
Parameters:
- `WDOG_W`, 20: watchdog counter width.
- `WDOG_LIMIT`, 20'd1000000: cycles from ISSUE entry until abort; 0 disables the watchdog.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: transfer request, level, per port.
- `wr0`, `wr1` in 1: writeRead per port.
- `mb0`, `mb1` in 1: multiblock per port.
- `bs0`, `bs1` in 4: blockSize per port.
- `toen0`, `toen1` in 1: timeoutenable per port.
- `to0`, `to1` in 16: timeout per port.
- `gnt0`, `gnt1` out 1: port owns the DAT path. One-hot or zero.
- `done0`, `done1` out 1: one-cycle pulse on transfer completion.
- `err0`, `err1` out 1: one-cycle pulse on watchdog abort.
- `busy` out 1: high in every state except IDLE.
- `dat_newService` out 1: to `control_DAT` `newService`.
- `dat_writeRead`, `dat_multiblock`, `dat_timeoutenable` out 1: latched configuration.
- `dat_blockSize` out 4, `dat_timeout` out 16: latched configuration.
- `dat_reset` out 1: active-high, to `control_DAT` `reset`.
- `dat_complete` in 1: from `control_DAT` `complete`.
- `dat_idle` in 1: from `control_DAT` `IDLE_out`.

## Operation
- All outputs are registered. On reset every output is 0, the state is IDLE, the watchdog count is 0 and `last` = 1, so port 0 wins the first tie.
- **IDLE**
  - Waits for `dat_idle`=1 and `req0|req1`.
  - A single requester wins. If both request, the port ≠ `last` wins (round-robin).
  - Latches the winner's config into `dat_*` and sets `gnt` → ISSUE.
  - No grant while `dat_idle`=0.
- **ISSUE**
  - `dat_newService`=1; the watchdog runs.
  - When `dat_idle` is sampled 0 (`control_DAT` left IDLE), drop `dat_newService` next cycle → WAIT_DONE.
- **WAIT_DONE**
  - The watchdog runs.
  - `dat_complete`=1 → pulse `done` of the granted port → RELEASE.
  - Watchdog reaching `WDOG_LIMIT` → ABORT.
- **ABORT**
  - `dat_reset`=1 for exactly 2 cycles, `dat_newService`=0.
  - `err` pulses on the first cycle → RELEASE.
- **RELEASE**
  - Waits for `dat_idle`=1, then clears `gnt`, sets `last` = served port → IDLE.
- **Watchdog**
  - `WDOG_W`-bit counter, cleared on ISSUE entry.
  - Increments each cycle in ISSUE/WAIT_DONE and saturates; never wraps.
  - Abort when count == `WDOG_LIMIT`. No abort when `WDOG_LIMIT`=0.
- **Boundary cases**
  - `req` deasserted after grant: ignored. The transfer completes and `done` still pulses.
  - Requester config changed after grant: ignored, because it was latched.
  - `dat_complete` and watchdog expiry in the same cycle: complete wins, `done` pulses and no `err`.
  - `dat_complete` seen while in ISSUE: ignored until WAIT_DONE.
  - Async reset mid-transfer: immediate return to reset values. `dat_reset` is not pulsed; the system reset covers `control_DAT`.
  - `done` and `err` are never both asserted, and never for the ungranted port.

## Timing
- **Grant latency:** `req` and `dat_idle` sampled high at edge N → `gnt`, config and `dat_newService` valid after edge N+1.
- **newService:** `dat_newService` stays high until one cycle after `dat_idle`=0 is sampled, minimum 1 cycle.
- **Done latency:** `done` rises the cycle after `dat_complete` is sampled high.
- **Grant release:** `gnt` falls the cycle after `dat_idle` is sampled high in RELEASE.
- **Back-to-back:** the next grant is earliest 1 cycle after the previous `gnt` falls. Minimum gap between transfers: 1 IDLE cycle.
- **Abort path:** `dat_reset` is high for cycles A and A+1. `err` pulses in cycle A.

## Test plan
- Single port-0 write, `bs0`=4'd3, `mb0`=1, model `control_DAT` finishing after 40 cycles → `gnt0` 1 cycle after `req0`, `dat_blockSize`=3, one `done0` pulse, `gnt0` drops after `dat_idle` returns.
- `req0` and `req1` asserted in the same cycle, held high for 4 transfers → grant order 0,1,0,1, with a 1-cycle IDLE gap between transfers.
- `WDOG_LIMIT`=100, model never asserts `complete` → `err1` pulses 100 cycles after ISSUE entry, `dat_reset` high for 2 cycles, `gnt1` released after `dat_idle`=1, no `done1`.
- `dat_complete` rises on the exact cycle the watchdog hits `WDOG_LIMIT` → `done` pulses, no `err`, no `dat_reset`.
- `reset` asserted low during WAIT_DONE → all outputs 0 immediately. After release the next grant goes to port 0 on a tie.
- `req0` dropped and `wr0`/`bs0` changed mid-transfer → `dat_*` outputs unchanged, `done0` still pulses.
